// File: rtl/dcp_cmd_dispatch.sv
// Debug control panel command dispatcher: reads one command character, looks it up in a packed
// opcode table and lends the SCAN/PRINT/addr/clk_cpu path to the matching child unit until it finishes.
module dcp_cmd_dispatch #(
    parameter int              N_CH       = 8,
    parameter int              DW         = 32,
    parameter int              AW         = 32,
    parameter logic [N_CH*8-1:0] CMD_LIST = 64'h58475447_4D445752,
    parameter bit              CASE_FOLD  = 1'b1,
    parameter logic [31:0]     TIMEOUT    = 32'd1000000,
    parameter logic [N_CH-1:0] NO_TO_MASK = '0,
    parameter logic [7:0]      ERR_CHAR   = 8'h3F
) (
    input  logic                 clk,
    input  logic                 rstn,
    output logic                 req_rx,
    output logic                 type_rx,
    input  logic                 ack_rx,
    input  logic                 flag_rx,
    input  logic [31:0]          din_rx,
    output logic                 req_tx,
    output logic                 type_tx,
    output logic [DW-1:0]        dout_tx,
    input  logic                 ack_tx,
    output logic [N_CH-1:0]      ch_start,
    output logic [N_CH-1:0]      ch_abort,
    input  logic [N_CH-1:0]      ch_req_rx,
    input  logic [N_CH-1:0]      ch_type_rx,
    input  logic [N_CH-1:0]      ch_req_tx,
    input  logic [N_CH-1:0]      ch_type_tx,
    input  logic [N_CH*DW-1:0]   ch_dout,
    input  logic [N_CH*AW-1:0]   ch_addr,
    input  logic [N_CH-1:0]      ch_clk_cpu,
    input  logic [N_CH-1:0]      ch_finish,
    output logic [AW-1:0]        addr,
    output logic                 clk_cpu,
    output logic [N_CH-1:0]      active_ch,
    output logic                 busy,
    output logic [15:0]          cmd_cnt,
    output logic [15:0]          err_cnt
);
    localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {IDLE, GET, RUN, ERR} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [N_CH-1:0] ch_start_q, ch_start_d;
    logic [N_CH-1:0] ch_abort_q, ch_abort_d;
    logic [31:0]     wd_q, wd_d;
    logic [15:0]     cmd_cnt_q, cmd_cnt_d;
    logic [15:0]     err_cnt_q, err_cnt_d;

    logic [DW-1:0]   dout_arr [N_CH];
    logic [AW-1:0]   addr_arr [N_CH];

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
        assign dout_arr[gi] = ch_dout[gi*DW +: DW];
        assign addr_arr[gi] = ch_addr[gi*AW +: AW];
    end

    // Only the low byte carries the command character.
    wire unused_din = &{1'b0, din_rx[31:8]};

    logic [7:0]    cmd_char;
    logic          hit;
    logic [SW-1:0] hit_idx;

    // Descending scan so the lowest matching channel is the one left standing.
    always_comb begin
        cmd_char = din_rx[7:0];
        if (CASE_FOLD && cmd_char >= 8'h61 && cmd_char <= 8'h7A)
            cmd_char = cmd_char - 8'h20;
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (CMD_LIST[8*i +: 8] == cmd_char) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    logic wd_expire;
    assign wd_expire = (TIMEOUT != 32'd0) && !NO_TO_MASK[sel_q] && !ack_rx && !ack_tx
                       && (wd_q == TIMEOUT - 32'd1);

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        ch_start_d = '0;
        ch_abort_d = '0;
        wd_d       = wd_q;
        cmd_cnt_d  = cmd_cnt_q;
        err_cnt_d  = err_cnt_q;
        case (state_q)
            IDLE: begin
                wd_d    = '0;
                state_d = GET;
            end
            GET: begin
                if (ack_rx) begin
                    if (!flag_rx && hit) begin
                        sel_d      = hit_idx;
                        ch_start_d = N_CH'(1) << hit_idx;
                        cmd_cnt_d  = cmd_cnt_q + 16'd1;
                        state_d    = RUN;
                    end else begin
                        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                        state_d = ERR;
                    end
                end
            end
            RUN: begin
                // A finishing channel is never aborted, even if the watchdog fires in the same cycle.
                if (ch_finish[sel_q]) begin
                    state_d = IDLE;
                end else if (wd_expire) begin
                    ch_abort_d = N_CH'(1) << sel_q;
                    if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                    state_d = IDLE;
                end else begin
                    wd_d = (ack_rx || ack_tx) ? 32'd0 : wd_q + 32'd1;
                end
            end
            ERR: begin
                if (ack_tx) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            ch_start_q <= '0;
            ch_abort_q <= '0;
            wd_q       <= '0;
            cmd_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            ch_start_q <= ch_start_d;
            ch_abort_q <= ch_abort_d;
            wd_q       <= wd_d;
            cmd_cnt_q  <= cmd_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Output path depends only on registered state/sel plus the owning child's signals.
    always_comb begin
        req_rx    = 1'b0;
        type_rx   = 1'b0;
        req_tx    = 1'b0;
        type_tx   = 1'b0;
        dout_tx   = '0;
        addr      = '0;
        clk_cpu   = 1'b0;
        active_ch = '0;
        case (state_q)
            GET: req_rx = 1'b1;
            RUN: begin
                req_rx    = ch_req_rx[sel_q];
                type_rx   = ch_type_rx[sel_q];
                req_tx    = ch_req_tx[sel_q];
                type_tx   = ch_type_tx[sel_q];
                dout_tx   = dout_arr[sel_q];
                addr      = addr_arr[sel_q];
                clk_cpu   = ch_clk_cpu[sel_q];
                active_ch = N_CH'(1) << sel_q;
            end
            ERR: begin
                req_tx  = 1'b1;
                dout_tx = DW'(ERR_CHAR);
            end
            default: ;
        endcase
    end

    assign busy     = (state_q == RUN) || (state_q == ERR);
    assign ch_start = ch_start_q;
    assign ch_abort = ch_abort_q;
    assign cmd_cnt  = cmd_cnt_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_dcp_cmd_dispatch.sv
// Directed bench for dcp_cmd_dispatch: instance A folds case and has a 16-cycle watchdog,
// instance B matches case exactly and exempts channel 2 from the watchdog.
module tb_dcp_cmd_dispatch;
    localparam int N  = 8;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam logic [63:0] CMDS = 64'h58475447_4D445752; // R W D M G T G X

    logic clk = 1'b0;
    logic rstn, ack_rx, flag_rx, ack_tx;
    logic [31:0] din_rx;
    logic [N-1:0] ch_req_rx, ch_type_rx, ch_req_tx, ch_type_tx, ch_clk_cpu, ch_finish;
    logic [N*DW-1:0] ch_dout;
    logic [N*AW-1:0] ch_addr;

    logic a_req_rx, a_type_rx, a_req_tx, a_type_tx, a_clk_cpu, a_busy;
    logic [DW-1:0] a_dout_tx;
    logic [AW-1:0] a_addr;
    logic [N-1:0] a_ch_start, a_ch_abort, a_active_ch;
    logic [15:0] a_cmd_cnt, a_err_cnt;

    logic b_req_rx, b_type_rx, b_req_tx, b_type_tx, b_clk_cpu, b_busy;
    logic [DW-1:0] b_dout_tx;
    logic [AW-1:0] b_addr;
    logic [N-1:0] b_ch_start, b_ch_abort, b_active_ch;
    logic [15:0] b_cmd_cnt, b_err_cnt;

    dcp_cmd_dispatch #(.N_CH(N), .DW(DW), .AW(AW), .CMD_LIST(CMDS), .CASE_FOLD(1'b1),
                       .TIMEOUT(32'd16), .NO_TO_MASK(8'h00), .ERR_CHAR(8'h3F)) u_a (
        .clk(clk), .rstn(rstn), .req_rx(a_req_rx), .type_rx(a_type_rx), .ack_rx(ack_rx),
        .flag_rx(flag_rx), .din_rx(din_rx), .req_tx(a_req_tx), .type_tx(a_type_tx),
        .dout_tx(a_dout_tx), .ack_tx(ack_tx), .ch_start(a_ch_start), .ch_abort(a_ch_abort),
        .ch_req_rx(ch_req_rx), .ch_type_rx(ch_type_rx), .ch_req_tx(ch_req_tx),
        .ch_type_tx(ch_type_tx), .ch_dout(ch_dout), .ch_addr(ch_addr), .ch_clk_cpu(ch_clk_cpu),
        .ch_finish(ch_finish), .addr(a_addr), .clk_cpu(a_clk_cpu), .active_ch(a_active_ch),
        .busy(a_busy), .cmd_cnt(a_cmd_cnt), .err_cnt(a_err_cnt));

    dcp_cmd_dispatch #(.N_CH(N), .DW(DW), .AW(AW), .CMD_LIST(CMDS), .CASE_FOLD(1'b0),
                       .TIMEOUT(32'd16), .NO_TO_MASK(8'h04), .ERR_CHAR(8'h3F)) u_b (
        .clk(clk), .rstn(rstn), .req_rx(b_req_rx), .type_rx(b_type_rx), .ack_rx(ack_rx),
        .flag_rx(flag_rx), .din_rx(din_rx), .req_tx(b_req_tx), .type_tx(b_type_tx),
        .dout_tx(b_dout_tx), .ack_tx(ack_tx), .ch_start(b_ch_start), .ch_abort(b_ch_abort),
        .ch_req_rx(ch_req_rx), .ch_type_rx(ch_type_rx), .ch_req_tx(ch_req_tx),
        .ch_type_tx(ch_type_tx), .ch_dout(ch_dout), .ch_addr(ch_addr), .ch_clk_cpu(ch_clk_cpu),
        .ch_finish(ch_finish), .addr(b_addr), .clk_cpu(b_clk_cpu), .active_ch(b_active_ch),
        .busy(b_busy), .cmd_cnt(b_cmd_cnt), .err_cnt(b_err_cnt));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int a_first, a_abort_n, b_abort_n;
    logic [N-1:0] a_abort_val;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c, input logic flag);
        int w = 0;
        while (a_req_rx !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk("wait_req_rx", {63'd0, a_req_rx}, 64'd1);
        din_rx  = {24'd0, c};
        flag_rx = flag;
        ack_rx  = 1'b1;
        tick();
        ack_rx  = 1'b0;
        flag_rx = 1'b0;
        din_rx  = '0;
        $display("cmd %02h flag %0d -> a_active %02h b_active %02h", c, flag, a_active_ch, b_active_ch);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic clear_ch();
        ch_req_rx = '0; ch_type_rx = '0; ch_req_tx = '0; ch_type_tx = '0;
        ch_clk_cpu = '0; ch_finish = '0; ch_dout = '0; ch_addr = '0;
    endtask

    task automatic run_watch(input int cycles, input int ack_at, input int fin_at);
        a_first = 0; a_abort_n = 0; b_abort_n = 0; a_abort_val = '0;
        for (int k = 1; k <= cycles; k++) begin
            ack_tx    = (k == ack_at);
            ch_finish = (k == fin_at) ? 8'h04 : 8'h00;
            if (a_ch_abort != 0) begin
                if (a_first == 0) a_first = k;
                a_abort_val = a_ch_abort;
                a_abort_n++;
            end
            if (b_ch_abort != 0) b_abort_n++;
            tick();
        end
        ack_tx    = 1'b0;
        ch_finish = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rstn = 1'b0; ack_rx = 1'b0; flag_rx = 1'b0; ack_tx = 1'b0; din_rx = '0;
        clear_ch();
        tick();
        tick();
        chk("rst_req_rx", {63'd0, a_req_rx}, 64'd0);
        chk("rst_busy", {63'd0, a_busy}, 64'd0);
        chk("rst_cmd_cnt", {48'd0, a_cmd_cnt}, 64'd0);
        chk("rst_err_cnt", {48'd0, a_err_cnt}, 64'd0);
        chk("rst_active", {56'd0, a_active_ch}, 64'd0);
        chk("rst_start", {56'd0, a_ch_start}, 64'd0);
        rstn = 1'b1;
        tick();
        chk("get_req_rx", {63'd0, a_req_rx}, 64'd1);
        chk("get_type_rx", {63'd0, a_type_rx}, 64'd0);

        // Dispatch 'D' to channel 2 and exercise the output mux.
        send(8'h44, 1'b0);
        chk("d_start", {56'd0, a_ch_start}, 64'h04);
        chk("d_active", {56'd0, a_active_ch}, 64'h04);
        chk("d_cmd_cnt", {48'd0, a_cmd_cnt}, 64'd1);
        chk("d_busy", {63'd0, a_busy}, 64'd1);
        chk("b_d_active", {56'd0, b_active_ch}, 64'h04);
        ch_addr[2*AW +: AW] = 32'h100;
        ch_addr[3*AW +: AW] = 32'h200;
        ch_dout[2*DW +: DW] = 32'hDEADBEEF;
        ch_dout[3*DW +: DW] = 32'h1234;
        ch_type_rx = 8'h04; ch_req_tx = 8'h04; ch_clk_cpu = 8'h08;
        #1;
        chk("mux_addr", {32'd0, a_addr}, 64'h100);
        chk("mux_dout", {32'd0, a_dout_tx}, 64'hDEADBEEF);
        chk("mux_req_tx", {63'd0, a_req_tx}, 64'd1);
        chk("mux_type_rx", {63'd0, a_type_rx}, 64'd1);
        chk("mux_req_rx", {63'd0, a_req_rx}, 64'd0);
        chk("mux_clk_other", {63'd0, a_clk_cpu}, 64'd0);
        ch_clk_cpu = 8'h04;
        #1;
        chk("mux_clk_sel", {63'd0, a_clk_cpu}, 64'd1);
        tick();
        chk("start_1cyc", {56'd0, a_ch_start}, 64'h00);
        ch_finish = 8'h08;
        tick();
        ch_finish = '0;
        chk("fin_other_ignored", {56'd0, a_active_ch}, 64'h04);
        ch_finish = 8'h04;
        tick();
        ch_finish = '0;
        chk("fin_idle_active", {56'd0, a_active_ch}, 64'h00);
        chk("fin_idle_addr", {32'd0, a_addr}, 64'h0);
        chk("fin_idle_req_rx", {63'd0, a_req_rx}, 64'd0);
        tick();
        chk("fin_req_rx_2cyc", {63'd0, a_req_rx}, 64'd1);
        clear_ch();

        // Lower-case 'd': folded by A, unknown to B.
        send(8'h64, 1'b0);
        chk("fold_active", {56'd0, a_active_ch}, 64'h04);
        chk("fold_cmd_cnt", {48'd0, a_cmd_cnt}, 64'd2);
        chk("nofold_active", {56'd0, b_active_ch}, 64'h00);
        chk("nofold_req_tx", {63'd0, b_req_tx}, 64'd1);
        chk("nofold_dout", {32'd0, b_dout_tx}, 64'h3F);
        chk("nofold_err_cnt", {48'd0, b_err_cnt}, 64'd1);
        tick();
        tick();
        chk("err_held", {63'd0, b_req_tx}, 64'd1);
        ack_tx = 1'b1;
        tick();
        ack_tx = 1'b0;
        chk("err_released", {63'd0, b_req_tx}, 64'd0);
        chk("err_busy", {63'd0, b_busy}, 64'd0);
        ch_finish = 8'h04;
        tick();
        ch_finish = '0;

        // Watchdog: A aborts after 16 idle RUN cycles, B is exempt on ch2.
        do_reset();
        send(8'h44, 1'b0);
        run_watch(1000, 0, 0);
        chk("wd_abort_cycle", a_first, 64'd17);
        chk("wd_abort_val", {56'd0, a_abort_val}, 64'h04);
        chk("wd_abort_1cyc", a_abort_n, 64'd1);
        chk("wd_err_cnt", {48'd0, a_err_cnt}, 64'd1);
        chk("exempt_no_abort", b_abort_n, 64'd0);
        chk("exempt_still_run", {56'd0, b_active_ch}, 64'h04);
        ch_finish = 8'h04;
        tick();
        ch_finish = '0;

        // ack_tx in cycle 10 restarts the watchdog.
        do_reset();
        send(8'h44, 1'b0);
        run_watch(40, 10, 0);
        chk("wd_ack_abort_cycle", a_first, 64'd27);
        chk("wd_ack_err_cnt", {48'd0, a_err_cnt}, 64'd1);

        // Finish in the expiry cycle beats the abort.
        do_reset();
        send(8'h44, 1'b0);
        run_watch(20, 0, 16);
        chk("race_no_abort", a_abort_n, 64'd0);
        chk("race_err_cnt", {48'd0, a_err_cnt}, 64'd0);
        chk("race_back_get", {63'd0, a_req_rx}, 64'd1);

        // Asynchronous reset in the middle of RUN.
        do_reset();
        send(8'h44, 1'b0);
        tick();
        tick();
        chk("pre_rst_busy", {63'd0, a_busy}, 64'd1);
        rstn = 1'b0;
        #2;
        chk("mid_rst_active", {56'd0, a_active_ch}, 64'h00);
        chk("mid_rst_busy", {63'd0, a_busy}, 64'd0);
        chk("mid_rst_cmd_cnt", {48'd0, a_cmd_cnt}, 64'd0);
        chk("mid_rst_abort", {56'd0, a_ch_abort}, 64'h00);
        tick();
        rstn = 1'b1;
        tick();
        chk("post_rst_req_rx", {63'd0, a_req_rx}, 64'd1);

        // Duplicate opcode 'G' on ch4 and ch6: lower index wins.
        send(8'h47, 1'b0);
        chk("dup_start", {56'd0, a_ch_start}, 64'h10);
        chk("dup_active", {56'd0, a_active_ch}, 64'h10);
        ch_finish = 8'h10;
        tick();
        ch_finish = '0;

        // rx error flag and unknown opcode both go to the error reply.
        send(8'h44, 1'b1);
        chk("flag_req_tx", {63'd0, a_req_tx}, 64'd1);
        chk("flag_dout", {32'd0, a_dout_tx}, 64'h3F);
        chk("flag_err_cnt", {48'd0, a_err_cnt}, 64'd1);
        chk("flag_cmd_cnt", {48'd0, a_cmd_cnt}, 64'd1);
        ack_tx = 1'b1;
        tick();
        ack_tx = 1'b0;
        send(8'h5A, 1'b0);
        chk("unk_req_tx", {63'd0, a_req_tx}, 64'd1);
        chk("unk_err_cnt", {48'd0, a_err_cnt}, 64'd2);
        ack_tx = 1'b1;
        tick();
        ack_tx = 1'b0;

        // A burst of dispatches to ch0.
        for (int n = 0; n < 20; n++) begin
            send(8'h52, 1'b0);
            ch_finish = 8'h01;
            tick();
            ch_finish = '0;
        end
        chk("burst_cmd_cnt", {48'd0, a_cmd_cnt}, 64'd21);
        chk("burst_err_cnt", {48'd0, a_err_cnt}, 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
